pc_sequencer: RTL

Multi-thread fetch program-counter unit for the pipelined MIPS core. It is the generalised successor of the single-thread PC register.
- Holds one PC per hardware thread.
- Picks one runnable thread per cycle by round-robin and issues its PC to instruction fetch.
- Applies branch/jump redirects and exception vectoring per thread, with a defined priority order.

---
 rtl/pc_seq_pkg.sv | 25 ++
 rtl/pc_sequencer_rr_arbiter.sv | 60 ++++++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the multi-thread fetch PC sequencer.
//   tid_w()            : width of a thread id for a given thread count (min 1)
//   DEFAULT_RESET_PC   : default PC loaded into every thread on reset
//   DEFAULT_EXC_VECTOR : default exception handler entry address
//   pc_src_e           : per-thread next-PC mux select (SEQ, REDIRECT, EXC)
// ---------------------------------------------------------------------------
package pc_seq_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0180;

    typedef enum logic [1:0] {
        SEQ      = 2'd0,
        REDIRECT = 2'd1,
        EXC      = 2'd2
    } pc_src_e;

    // A single-thread build still carries a 1-bit tid so port widths stay legal.
    function automatic int tid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_sequencer_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered pointer. The search starts one past
// the last granted index, so the most recent winner has lowest priority.
// Ports:
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_req            : per-requester request vector
//   i_advance        : when 1, pointer moves to the current grant (if any)
//   o_grant_valid    : at least one request is active
//   o_grant          : one-hot grant (all zero when no request)
//   o_grant_idx      : index of the granted requester
// ---------------------------------------------------------------------------
module rr_arbiter
    import pc_seq_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = tid_w(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic               o_grant_valid,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx
);

    logic [IDX_W-1:0] ptr;
    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    int               cand;

    // Walk requesters starting at ptr+1 and wrapping; first active one wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!grant_found && i_req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    assign o_grant_valid = grant_found;
    assign o_grant_idx   = grant_idx;
    assign o_grant       = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;

    // Reset points at the last requester so index 0 wins first.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr <= IDX_W'(NUM_REQ - 1);
        end else if (i_advance && grant_found) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Multi-thread fetch program-counter unit. Holds one PC per hardware thread,
// picks one enabled thread per cycle round-robin and issues its PC to fetch.
// Redirects and exceptions are bypassed into the same-cycle grant.
// Ports:
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_stall            : freeze fetch outputs, pointer and PC increments
//   i_thread_en        : per-thread run enable
//   i_redirect_*       : taken branch/jump (valid, thread, target)
//   i_exc_*            : exception raised (valid, faulting thread)
//   o_fetch_valid/tid/pc : registered fetch request
//   o_epc              : PC of the faulting thread captured at exception
// ---------------------------------------------------------------------------
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter  int                ADDR_W      = 32,
    parameter  int                NUM_THREADS = 2,
    parameter  logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEFAULT_RESET_PC),
    parameter  logic [ADDR_W-1:0] EXC_VECTOR  = ADDR_W'(DEFAULT_EXC_VECTOR),
    parameter  int                INSTR_BYTES = 4,
    localparam int                TID_W       = tid_w(NUM_THREADS)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_stall,
    input  logic [NUM_THREADS-1:0] i_thread_en,
    input  logic                   i_redirect_valid,
    input  logic [TID_W-1:0]       i_redirect_tid,
    input  logic [ADDR_W-1:0]      i_redirect_pc,
    input  logic                   i_exc_valid,
    input  logic [TID_W-1:0]       i_exc_tid,
    output logic                   o_fetch_valid,
    output logic [TID_W-1:0]       o_fetch_tid,
    output logic [ADDR_W-1:0]      o_fetch_pc,
    output logic [ADDR_W-1:0]      o_epc
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_BYTES - 1);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);

    logic [ADDR_W-1:0]      pc     [NUM_THREADS];
    logic [ADDR_W-1:0]      eff_pc [NUM_THREADS];
    pc_src_e                pc_src [NUM_THREADS];
    logic [ADDR_W-1:0]      redirect_aligned;
    logic                   exc_in_range;

    logic                   grant_valid;
    logic [NUM_THREADS-1:0] grant_onehot;
    logic [TID_W-1:0]       grant_idx;

    rr_arbiter #(
        .NUM_REQ       (NUM_THREADS)
    ) u_arb (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_req         (i_thread_en),
        .i_advance     (!i_stall),
        .o_grant_valid (grant_valid),
        .o_grant       (grant_onehot),
        .o_grant_idx   (grant_idx)
    );

    assign redirect_aligned = i_redirect_pc & ALIGN_MASK;
    assign exc_in_range     = i_exc_valid && (int'(i_exc_tid) < NUM_THREADS);

    // Per-thread effective PC: exception beats redirect beats the stored PC.
    // Tids outside the thread range never match any t, so they are ignored.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            pc_src[t] = SEQ;
            if (i_exc_valid && (int'(i_exc_tid) == t)) begin
                pc_src[t] = EXC;
            end else if (i_redirect_valid && (int'(i_redirect_tid) == t)) begin
                pc_src[t] = REDIRECT;
            end
            case (pc_src[t])
                EXC:      eff_pc[t] = EXC_VECTOR;
                REDIRECT: eff_pc[t] = redirect_aligned;
                default:  eff_pc[t] = pc[t];
            endcase
        end
    end

    // Only the granted thread advances, and only when not stalled; every
    // other thread simply absorbs any redirect/exception aimed at it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc[t] <= RESET_PC;
            end
            o_fetch_valid <= 1'b0;
            o_fetch_tid   <= '0;
            o_fetch_pc    <= '0;
            o_epc         <= '0;
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (!i_stall && grant_onehot[t]) begin
                    pc[t] <= eff_pc[t] + STEP;
                end else begin
                    pc[t] <= eff_pc[t];
                end
            end

            if (exc_in_range) begin
                o_epc <= pc[i_exc_tid];
            end

            if (!i_stall) begin
                if (grant_valid) begin
                    o_fetch_valid <= 1'b1;
                    o_fetch_tid   <= grant_idx;
                    o_fetch_pc    <= eff_pc[grant_idx];
                end else begin
                    o_fetch_valid <= 1'b0;
                end
            end
        end
    end

endmodule
